sram_1r1w_arbiter: RTL and testbench

- Shares one 16K x 16 1R1W output-buffer SRAM between NUM_REQ requesters (Bellman-Ford update lanes).
- Runs independent round-robin arbitration on the read port and the write port, so one read and one write can be accepted per cycle.
- Registers every SRAM input and captures ReadBus into an output register, giving a fixed 2-cycle read latency.
- Forwards write data on a same-cycle read/write address match, so write-then-read ordering holds.

---
 rtl/sram_1r1w_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_1r1w_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_arbiter.sv
// Round-robin sharing of a 1R1W SRAM between NUM_REQ requesters.
// The read and write ports are arbitrated independently. Every SRAM input
// is registered, read data is captured into an output register, and a
// write to the address being read in the same cycle is forwarded.
module sram_1r1w_arbiter #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_REQ-1:0]          rd_gnt,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    input  logic [NUM_REQ-1:0]          wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
    output logic [NUM_REQ-1:0]          wr_gnt,
    output logic                        mem_WE,
    output logic [ADDR_W-1:0]           mem_WriteAddress,
    output logic [ADDR_W-1:0]           mem_ReadAddress,
    output logic [DATA_W-1:0]           mem_WriteBus,
    input  logic [DATA_W-1:0]           mem_ReadBus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdWin;
    logic [PTR_W-1:0]  wrWin;
    logic              rdAccept;
    logic              wrAccept;
    logic [ADDR_W-1:0] rdAddrSel;
    logic [ADDR_W-1:0] wrAddrSel;
    logic [DATA_W-1:0] wrDataSel;
    logic              readPend;
    logic [PTR_W-1:0]  readTag;
    logic              fwdHit;

    // First asserted request found searching from ptr+1 upward, wrapping.
    function automatic logic [NUM_REQ-1:0] rrGrant(
        input logic [NUM_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] gnt;
        logic [PTR_W-1:0]   idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    // Index of the single set bit of a one-hot grant.
    function automatic logic [PTR_W-1:0] oneHotIdx(input logic [NUM_REQ-1:0] gnt);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    // Grants, winners and the winner's address/data selection.
    always_comb begin
        rd_gnt    = '0;
        wr_gnt    = '0;
        if (!reset) begin
            rd_gnt = rrGrant(rd_req, rdPtr);
            wr_gnt = rrGrant(wr_req, wrPtr);
        end
        rdWin     = oneHotIdx(rd_gnt);
        wrWin     = oneHotIdx(wr_gnt);
        rdAccept  = |rd_gnt;
        wrAccept  = |wr_gnt;
        rdAddrSel = rd_addr[32'(rdWin) * ADDR_W +: ADDR_W];
        wrAddrSel = wr_addr[32'(wrWin) * ADDR_W +: ADDR_W];
        wrDataSel = wr_data[32'(wrWin) * DATA_W +: DATA_W];
        fwdHit    = mem_WE && (mem_WriteAddress == mem_ReadAddress);
    end

    // Write port: register the accepted write and advance its RR pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_WE           <= 1'b0;
            mem_WriteAddress <= '0;
            mem_WriteBus     <= '0;
            wrPtr            <= PTR_W'(NUM_REQ - 1);
        end else begin
            mem_WE <= wrAccept;
            if (wrAccept) begin
                mem_WriteAddress <= wrAddrSel;
                mem_WriteBus     <= wrDataSel;
                wrPtr            <= wrWin;
            end
        end
    end

    // Read port: register the accepted address, then capture data a cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_ReadAddress <= '0;
            readPend        <= 1'b0;
            readTag         <= '0;
            rd_valid        <= '0;
            rd_data         <= '0;
            rdPtr           <= PTR_W'(NUM_REQ - 1);
        end else begin
            readPend <= rdAccept;
            if (rdAccept) begin
                mem_ReadAddress <= rdAddrSel;
                readTag         <= rdWin;
                rdPtr           <= rdWin;
            end
            if (readPend) begin
                rd_data  <= fwdHit ? mem_WriteBus : mem_ReadBus;
                rd_valid <= NUM_REQ'(1) << readTag;
            end else begin
                rd_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// Directed bench for sram_1r1w_arbiter with a behavioural 16K x 16 SRAM.
module tb_sram_1r1w_arbiter;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_REQ = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_gnt;
    logic                      mem_WE;
    logic [ADDR_W-1:0]         mem_WriteAddress;
    logic [ADDR_W-1:0]         mem_ReadAddress;
    logic [DATA_W-1:0]         mem_WriteBus;
    logic [DATA_W-1:0]         mem_ReadBus;

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic              memClear;

    int errors = 0;
    int checks = 0;

    sram_1r1w_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
        .clock(clock), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_WE(mem_WE), .mem_WriteAddress(mem_WriteAddress),
        .mem_ReadAddress(mem_ReadAddress), .mem_WriteBus(mem_WriteBus),
        .mem_ReadBus(mem_ReadBus)
    );

    always #5 clock = ~clock;

    // SRAM model: synchronous write, combinational read.
    always @(posedge clock) begin
        if (memClear) begin
            for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= '0;
        end else if (mem_WE) begin
            sram[mem_WriteAddress] <= mem_WriteBus;
        end
    end
    assign mem_ReadBus = sram[mem_ReadAddress];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setRd(input int unsigned r, input logic [ADDR_W-1:0] a);
        rd_addr[r*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic setWr(input int unsigned r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_addr[r*ADDR_W +: ADDR_W] = a;
        wr_data[r*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        reset    = 1'b1;
        memClear = 1'b1;
        rd_req   = '0;
        rd_addr  = '0;
        wr_req   = '0;
        wr_addr  = '0;
        wr_data  = '0;
        tick();
        tick();
        memClear = 1'b0;

        // Grants stay low while reset is high, even with requests present.
        rd_req = 2'b11;
        wr_req = 2'b11;
        #1;
        chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        rd_req = '0;
        wr_req = '0;
        reset  = 1'b0;

        // Idle after reset: all outputs low, no write strobe.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_we", 32'(mem_WE), 32'h0);
            chk("idle_rv", 32'(rd_valid), 32'h0);
        end
        chk("idle_rdata", 32'(rd_data), 32'h0);
        chk("idle_waddr", 32'(mem_WriteAddress), 32'h0);
        chk("idle_raddr", 32'(mem_ReadAddress), 32'h0);
        chk("idle_wbus", 32'(mem_WriteBus), 32'h0);

        // Req0 writes 0x0005=BEEF, req1 reads it back two cycles later.
        wr_req = 2'b01;
        setWr(0, 14'h0005, 16'hBEEF);
        #1;
        chk("t2_wr_gnt", 32'(wr_gnt), 32'h1);
        tick();
        wr_req = '0;
        chk("t2_we", 32'(mem_WE), 32'h1);
        chk("t2_waddr", 32'(mem_WriteAddress), 32'h5);
        chk("t2_wbus", 32'(mem_WriteBus), 32'hBEEF);
        tick();
        chk("t2_we_drop", 32'(mem_WE), 32'h0);
        rd_req = 2'b10;
        setRd(1, 14'h0005);
        #1;
        chk("t2_rd_gnt", 32'(rd_gnt), 32'h2);
        tick();
        rd_req = '0;
        chk("t2_rv_early", 32'(rd_valid), 32'h0);
        tick();
        chk("t2_rv", 32'(rd_valid), 32'h2);
        chk("t2_rdata", 32'(rd_data), 32'hBEEF);
        tick();
        chk("t2_rv_once", 32'(rd_valid), 32'h0);

        // Preload 0x0010=1111 (req0) and 0x0020=2222 (req1).
        wr_req = 2'b01;
        setWr(0, 14'h0010, 16'h1111);
        #1;
        chk("t3_pre0_gnt", 32'(wr_gnt), 32'h1);
        tick();
        wr_req = 2'b10;
        setWr(1, 14'h0020, 16'h2222);
        #1;
        chk("t3_pre1_gnt", 32'(wr_gnt), 32'h2);
        tick();
        wr_req = '0;
        tick();

        // Both requesters read continuously: grants alternate starting at req0.
        rd_req = 2'b11;
        setRd(0, 14'h0010);
        setRd(1, 14'h0020);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_rd_gnt", 32'(rd_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            if (k >= 1) begin
                chk("t3_rv", 32'(rd_valid), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
                chk("t3_rdata", 32'(rd_data), ((k - 1) % 2 == 0) ? 32'h1111 : 32'h2222);
            end
        end
        rd_req = '0;
        tick();
        chk("t3_rv_last", 32'(rd_valid), 32'h2);
        chk("t3_rdata_last", 32'(rd_data), 32'h2222);
        tick();
        chk("t3_rv_idle", 32'(rd_valid), 32'h0);

        // Same-cycle write and read of 0x3FFF: data comes from the forward path.
        wr_req = 2'b01;
        setWr(0, 14'h3FFF, 16'hA5A5);
        rd_req = 2'b10;
        setRd(1, 14'h3FFF);
        #1;
        chk("t4_wr_gnt", 32'(wr_gnt), 32'h1);
        chk("t4_rd_gnt", 32'(rd_gnt), 32'h2);
        tick();
        wr_req = '0;
        rd_req = '0;
        chk("t4_raddr", 32'(mem_ReadAddress), 32'h3FFF);
        tick();
        chk("t4_rv", 32'(rd_valid), 32'h2);
        chk("t4_rdata_fwd", 32'(rd_data), 32'hA5A5);

        // Write 0x3FFF=5A5A (req1), read it (req0) one cycle later.
        wr_req = 2'b10;
        setWr(1, 14'h3FFF, 16'h5A5A);
        #1;
        chk("t4b_wr_gnt", 32'(wr_gnt), 32'h2);
        tick();
        wr_req = '0;
        rd_req = 2'b01;
        setRd(0, 14'h3FFF);
        #1;
        chk("t4b_rd_gnt", 32'(rd_gnt), 32'h1);
        tick();
        rd_req = '0;
        tick();
        chk("t4b_rv", 32'(rd_valid), 32'h1);
        chk("t4b_rdata", 32'(rd_data), 32'h5A5A);

        // Both write 0x0100 together: req0 first, req1 second; last one sticks.
        wr_req = 2'b11;
        setWr(0, 14'h0100, 16'h0001);
        setWr(1, 14'h0100, 16'h0002);
        #1;
        chk("t5_gnt_first", 32'(wr_gnt), 32'h1);
        tick();
        chk("t5_wbus_first", 32'(mem_WriteBus), 32'h0001);
        chk("t5_gnt_second", 32'(wr_gnt), 32'h2);
        tick();
        wr_req = '0;
        chk("t5_wbus_second", 32'(mem_WriteBus), 32'h0002);
        tick();
        rd_req = 2'b01;
        setRd(0, 14'h0100);
        #1;
        chk("t5_rd_gnt", 32'(rd_gnt), 32'h1);
        tick();
        rd_req = '0;
        tick();
        chk("t5_rv", 32'(rd_valid), 32'h1);
        chk("t5_rdata", 32'(rd_data), 32'h0002);

        // Reset with a write and reads in flight.
        rd_req = 2'b10;
        setRd(1, 14'h0010);
        #1;
        chk("t6_rd_gnt_a", 32'(rd_gnt), 32'h2);
        tick();
        rd_req = 2'b01;
        setRd(0, 14'h0020);
        wr_req = 2'b01;
        setWr(0, 14'h0200, 16'h7777);
        #1;
        chk("t6_rd_gnt_b", 32'(rd_gnt), 32'h1);
        chk("t6_wr_gnt", 32'(wr_gnt), 32'h1);
        tick();
        rd_req = '0;
        wr_req = '0;
        chk("t6_we_pre", 32'(mem_WE), 32'h1);
        chk("t6_rv_pre", 32'(rd_valid), 32'h2);
        chk("t6_rdata_pre", 32'(rd_data), 32'h1111);
        reset = 1'b1;
        #1;
        chk("t6_we_rst", 32'(mem_WE), 32'h0);
        chk("t6_rv_rst", 32'(rd_valid), 32'h0);
        chk("t6_waddr_rst", 32'(mem_WriteAddress), 32'h0);
        tick();
        chk("t6_sram_kept", 32'(sram[14'h0200]), 32'h0);
        reset = 1'b0;
        tick();
        chk("t6_rv_after", 32'(rd_valid), 32'h0);
        rd_req = 2'b11;
        setRd(0, 14'h0200);
        setRd(1, 14'h0010);
        wr_req = 2'b11;
        setWr(0, 14'h0300, 16'h1234);
        setWr(1, 14'h0300, 16'h5678);
        #1;
        chk("t6_rd_gnt_post", 32'(rd_gnt), 32'h1);
        chk("t6_wr_gnt_post", 32'(wr_gnt), 32'h1);
        tick();
        rd_req = '0;
        wr_req = '0;
        tick();
        chk("t6_rv_post", 32'(rd_valid), 32'h1);
        chk("t6_rdata_post", 32'(rd_data), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
